// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM states, frame magic byte
// and LEN field width.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } boot_state_t;

  localparam logic [7:0]  BOOT_MAGIC = 8'hA5;
  localparam int unsigned LEN_W      = 16;

  // States in which a stalled link is timed out.
  function automatic logic in_frame(input boot_state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Registered rising-edge detector on the receiver's byte_ready level; captures
// the byte in the same cycle so consumers see strobe and data together.
module uart_byte_strobe (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       byte_ready_i,
  input  logic [7:0] byte_i,
  output logic       strobe_o,
  output logic [7:0] byte_o
);

  logic       ready_q, ready_d;
  logic       strobe_q, strobe_d;
  logic [7:0] byte_q, byte_d;

  // Edge detect and byte capture.
  always_comb begin
    ready_d  = byte_ready_i;
    strobe_d = byte_ready_i & ~ready_q;
    if (strobe_d) begin
      byte_d = byte_i;
    end else begin
      byte_d = byte_q;
    end
  end

  // Strobe/byte registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q  <= 1'b0;
      strobe_q <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      ready_q  <= ready_d;
      strobe_q <= strobe_d;
      byte_q   <= byte_d;
    end
  end

  assign strobe_o = strobe_q;
  assign byte_o   = byte_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Turns a framed UART byte stream (A5, LEN, payload words, XOR checksum) into
// instruction-RAM writes, holding the CPU in reset until a good image lands.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Expiry fires on the cycle the idle count would step onto TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [31:0]      CAPACITY = 32'd1 << ADDR_W;

  logic       strobe;
  logic [7:0] rx_byte;

  uart_byte_strobe u_strobe (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_ready_i (byte_ready_i),
    .byte_i       (byte_i),
    .strobe_o     (strobe),
    .byte_o       (rx_byte)
  );

  boot_state_t       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  widx_q, widx_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic [LEN_W-1:0]  len_full;

  // Next-state, word assembly, checksum and idle-timeout logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    widx_d      = widx_q;
    lane_d      = lane_q;
    word_d      = word_q;
    csum_d      = csum_q;
    cnt_d       = '0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    cpu_reset_d = cpu_reset_q;
    len_full    = {rx_byte, len_q[7:0]};

    if (in_frame(state_q) && !strobe) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_ERROR;
        error_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (strobe && (rx_byte == BOOT_MAGIC)) begin
          state_d = ST_LEN0;
          error_d = 1'b0;
          csum_d  = 8'h00;
        end
      end
      ST_LEN0: begin
        if (strobe) begin
          len_d[7:0] = rx_byte;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (strobe) begin
          len_d = len_full;
          if (32'(len_full) > CAPACITY) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
            widx_d  = 16'd0;
            lane_d  = 2'd0;
          end
        end
      end
      ST_DATA: begin
        if (strobe) begin
          // Little-endian: shifting right leaves the first byte in lane 0.
          word_d = {rx_byte, word_q[31:8]};
          csum_d = csum_q ^ rx_byte;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(BASE_ADDR + 32'(widx_q));
            wdata_d = word_d;
            widx_d  = widx_q + 16'd1;
            if (widx_q == (len_q - 16'd1)) begin
              state_d = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        if (strobe) begin
          if (rx_byte == csum_q) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      widx_q      <= '0;
      lane_q      <= 2'd0;
      word_q      <= 32'h0;
      csum_q      <= 8'h00;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign cpu_reset_o = cpu_reset_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: frames are built from random or
// fixed payload words and the expected writes/status derived from frame rules.
module tb_uart_boot_loader;

  localparam int ADDR_W  = 4;
  localparam int BASE    = 0;
  localparam int TIMEOUT = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_ready = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset, done, error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]        frame[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];

  uart_boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_i       (byte_in),
    .byte_ready_i (byte_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .cpu_reset_o  (cpu_reset),
    .done_o       (done),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wdata);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    byte_in = b;
    byte_ready = 1'b1;
    repeat (2) @(negedge clk);
    byte_ready = 1'b0;
    repeat (gap + 1) @(negedge clk);
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i], $urandom_range(0, 3));
    repeat (5) @(negedge clk);
  endtask

  // Reference: frame bytes, expected writes and checksum straight from the frame rules.
  task automatic build_frame(input logic [31:0] words[$], input bit bad);
    logic [7:0]  cs;
    logic [31:0] w;
    int          n;
    cs = 8'h00;
    n = words.size();
    frame.delete();
    exp_addr.delete();
    exp_data.delete();
    frame.push_back(8'hA5);
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    for (int k = 0; k < n; k++) begin
      w = words[k];
      for (int l = 0; l < 4; l++) begin
        frame.push_back(8'(w >> (8 * l)));
        cs = cs ^ 8'(w >> (8 * l));
      end
      exp_addr.push_back(ADDR_W'((BASE + k) % (1 << ADDR_W)));
      exp_data.push_back(w);
    end
    frame.push_back(bad ? (cs ^ 8'h88) : cs);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 6;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", error); end
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
  endtask

  task automatic test_valid_load();
    logic [31:0] w[$];
    do_reset();
    w = '{32'h44332211, 32'h88776655};
    build_frame(w, 1'b0);
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_frame();
    n_checks++;
    if (cap_addr.size() !== 2) begin n_fail++; $display("FAIL valid_write_count got=%0d exp=2", cap_addr.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL valid_write%0d got=%h:%h exp=%h:%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    n_checks += 3;
    if (done !== 1'b1) begin n_fail++; $display("FAIL valid_done got=%b exp=1", done); end
    if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL valid_cpu_reset got=%b exp=0", cpu_reset); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL valid_error got=%b exp=0", error); end
    // Everything after DONE is ignored.
    cap_addr.delete();
    cap_data.delete();
    send_frame();
    n_checks += 2;
    if (cap_addr.size() !== 0) begin n_fail++; $display("FAIL done_ignores_writes got=%0d exp=0", cap_addr.size()); end
    if (done !== 1'b1 || cpu_reset !== 1'b0) begin n_fail++; $display("FAIL done_sticky got=%b/%b exp=1/0", done, cpu_reset); end
  endtask

  task automatic test_bad_then_good();
    logic [31:0] w[$];
    do_reset();
    w = '{32'h44332211, 32'h88776655};
    build_frame(w, 1'b1);
    n_checks++;
    if (frame[frame.size() - 1] !== 8'h00) begin n_fail++; $display("FAIL bad_csum_byte got=%h exp=00", frame[frame.size() - 1]); end
    send_frame();
    n_checks += 4;
    if (cap_addr.size() !== 2) begin n_fail++; $display("FAIL bad_write_count got=%0d exp=2", cap_addr.size()); end
    if (error !== 1'b1) begin n_fail++; $display("FAIL bad_error got=%b exp=1", error); end
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL bad_cpu_reset got=%b exp=1", cpu_reset); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL bad_done got=%b exp=0", done); end
    build_frame(w, 1'b0);
    send_byte(8'hA5, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL magic_clears_error got=%b exp=0", error); end
    frame.pop_front();
    send_frame();
    n_checks += 2;
    if (done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL retry_status got=%b/%b exp=1/0", done, error); end
    if (cap_addr.size() !== 4) begin n_fail++; $display("FAIL retry_write_count got=%0d exp=4", cap_addr.size()); end
  endtask

  task automatic test_zero_and_oversize();
    logic [31:0] w[$];
    do_reset();
    w.delete();
    build_frame(w, 1'b0);
    send_frame();
    n_checks += 2;
    if (done !== 1'b1 || cpu_reset !== 1'b0) begin n_fail++; $display("FAIL zero_len_done got=%b/%b exp=1/0", done, cpu_reset); end
    if (cap_addr.size() !== 0) begin n_fail++; $display("FAIL zero_len_writes got=%0d exp=0", cap_addr.size()); end
    do_reset();
    frame = '{8'hA5, 8'h11, 8'h00};
    send_frame();
    n_checks += 2;
    if (error !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL oversize_error got=%b/%b exp=1/0", error, done); end
    if (cap_addr.size() !== 0) begin n_fail++; $display("FAIL oversize_writes got=%0d exp=0", cap_addr.size()); end
  endtask

  task automatic test_timeout();
    int first;
    do_reset();
    frame = '{8'hA5, 8'h01, 8'h00};
    foreach (frame[i]) send_byte(frame[i], 1);
    @(negedge clk);
    byte_in = 8'hAA;
    byte_ready = 1'b1;
    first = 0;
    // Edge 1 samples the level, edge 2 consumes the strobe; expiry lands TIMEOUT cycles later.
    for (int k = 1; k <= TIMEOUT + 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) byte_ready = 1'b0;
      if (error === 1'b1 && first == 0) first = k;
    end
    n_checks += 2;
    if (first !== TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_edge got=%0d exp=%0d", first, TIMEOUT + 1); end
    if (cap_addr.size() !== 0) begin n_fail++; $display("FAIL timeout_writes got=%0d exp=0", cap_addr.size()); end
  endtask

  task automatic test_held_level();
    logic [31:0] w[$];
    do_reset();
    w = '{32'($urandom)};
    build_frame(w, 1'b0);
    send_byte(frame[0], 0);
    @(negedge clk);
    byte_in = frame[1];
    byte_ready = 1'b1;
    repeat (50) @(negedge clk);
    byte_ready = 1'b0;
    @(negedge clk);
    for (int i = 2; i < frame.size(); i++) send_byte(frame[i], 0);
    repeat (5) @(negedge clk);
    n_checks += 2;
    if (done !== 1'b1) begin n_fail++; $display("FAIL held_level_done got=%b exp=1", done); end
    if (cap_addr.size() !== 1 || cap_data[0] !== exp_data[0]) begin
      n_fail++;
      $display("FAIL held_level_write got=%0d writes exp=1 of %h", cap_addr.size(), exp_data[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w[$];
    do_reset();
    w = '{32'hDEADBEEF, 32'h01234567};
    build_frame(w, 1'b1);
    send_frame();
    build_frame(w, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
    do_reset();
    n_checks += 4;
    if (error !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_flags got=%b/%b exp=0/0", error, done); end
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL midreset_cpu_reset got=%b exp=1", cpu_reset); end
    if (mem_addr !== '0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL midreset_addr got=%h/%b exp=0/0", mem_addr, mem_we); end
    if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL midreset_wdata got=%h exp=0", mem_wdata); end
    w = '{32'($urandom), 32'($urandom), 32'($urandom)};
    build_frame(w, 1'b0);
    send_frame();
    n_checks++;
    if (cap_addr.size() !== 3) begin n_fail++; $display("FAIL midreset_refill_count got=%0d exp=3", cap_addr.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL midreset_refill%0d got=%h:%h exp=%h:%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    logic [31:0] w[$];
    int          len;
    bit          bad;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      len = (it == 0) ? (1 << ADDR_W) : int'($urandom_range(1, 1 << ADDR_W));
      bad = 1'($urandom_range(0, 1));
      w.delete();
      for (int k = 0; k < len; k++) w.push_back(32'($urandom));
      build_frame(w, bad);
      send_frame();
      n_checks++;
      if (cap_addr.size() !== exp_addr.size()) begin
        n_fail++;
        $display("FAIL rand%0d_write_count got=%0d exp=%0d", it, cap_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          n_checks++;
          if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL rand%0d_write%0d got=%h:%h exp=%h:%h", it, i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      n_checks++;
      if (done !== !bad || error !== bad || cpu_reset !== bad) begin
        n_fail++;
        $display("FAIL rand%0d_status got done=%b err=%b rst=%b exp bad=%b", it, done, error, cpu_reset, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_load();
    test_bad_then_good();
    test_zero_and_oversize();
    test_timeout();
    test_held_level();
    test_reset_mid_frame();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
